// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two
// valid/ready requesters. Operands are registered onto the ALU inputs on a
// request handshake. The ALU result is captured one cycle later and held
// until the owning requester accepts it.
module alu_arbiter #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              Req_Valid_0,
   input  logic              Req_Valid_1,
   output logic              Req_Ready_0,
   output logic              Req_Ready_1,
   input  logic [2:0]        Req_Sel_0,
   input  logic [2:0]        Req_Sel_1,
   input  logic [DATA_W-1:0] Req_A_0,
   input  logic [DATA_W-1:0] Req_B_0,
   input  logic [DATA_W-1:0] Req_A_1,
   input  logic [DATA_W-1:0] Req_B_1,
   output logic              Rsp_Valid_0,
   output logic              Rsp_Valid_1,
   input  logic              Rsp_Ready_0,
   input  logic              Rsp_Ready_1,
   output logic [DATA_W-1:0] Rsp_Data,
   output logic              Rsp_Err,
   output logic [DATA_W-1:0] ALU_In_0,
   output logic [DATA_W-1:0] ALU_In_1,
   output logic [2:0]        ALU_Sel,
   input  logic [DATA_W-1:0] ALU_Out,
   output logic              Busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t            state_q, state_d;
   logic              prio_q;      // requester favoured when both are valid
   logic              owner_q;     // requester that owns the in-flight op
   logic [DATA_W-1:0] alu_in_0_q, alu_in_1_q;
   logic [2:0]        alu_sel_q;
   logic [DATA_W-1:0] rsp_data_q;
   logic              rsp_err_q;

   logic grant_0, grant_1;
   logic req_fire, rsp_fire;

   // Round-robin grant: the sole valid requester wins, ties go to prio_q.
   always_comb begin
      grant_0 = Req_Valid_0 & (~Req_Valid_1 | ~prio_q);
      grant_1 = Req_Valid_1 & (~Req_Valid_0 |  prio_q);
   end

   // Next-state logic and the handshake-related outputs.
   always_comb begin
      state_d     = state_q;
      Req_Ready_0 = 1'b0;
      Req_Ready_1 = 1'b0;
      Rsp_Valid_0 = 1'b0;
      Rsp_Valid_1 = 1'b0;
      req_fire    = 1'b0;
      rsp_fire    = 1'b0;
      case (state_q)
         IDLE: begin
            Req_Ready_0 = grant_0;
            Req_Ready_1 = grant_1;
            req_fire    = grant_0 | grant_1;
            if (req_fire) state_d = EXEC;
         end
         EXEC: state_d = RESP;
         RESP: begin
            Rsp_Valid_0 = ~owner_q;
            Rsp_Valid_1 =  owner_q;
            rsp_fire    = owner_q ? Rsp_Ready_1 : Rsp_Ready_0;
            if (rsp_fire) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM state, ownership and priority pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         prio_q  <= 1'b0;
         owner_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (req_fire) begin
            owner_q <= grant_1;
            // Pointer moves away from the winner, even for a lone requester.
            prio_q  <= ~grant_1;
         end
      end
   end

   // ALU input registers load the winner's operands and keep them afterwards.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_in_0_q <= '0;
         alu_in_1_q <= '0;
         alu_sel_q  <= 3'b000;
      end else if (req_fire) begin
         alu_in_0_q <= grant_1 ? Req_A_1   : Req_A_0;
         alu_in_1_q <= grant_1 ? Req_B_1   : Req_B_0;
         alu_sel_q  <= grant_1 ? Req_Sel_1 : Req_Sel_0;
      end
   end

   // Result capture in EXEC; illegal opcodes force zero data and flag an error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
      end else if (state_q == EXEC) begin
         if (alu_sel_q >= 3'b101) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
         end else begin
            rsp_data_q <= ALU_Out;
            rsp_err_q  <= 1'b0;
         end
      end
   end

   assign ALU_In_0 = alu_in_0_q;
   assign ALU_In_1 = alu_in_1_q;
   assign ALU_Sel  = alu_sel_q;
   assign Rsp_Data = rsp_data_q;
   assign Rsp_Err  = rsp_err_q;
   assign Busy     = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU attached to the
// ALU ports. Expected values are hand-computed constants.
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        Req_Valid_0, Req_Valid_1, Req_Ready_0, Req_Ready_1;
   logic [2:0]  Req_Sel_0, Req_Sel_1;
   logic [31:0] Req_A_0, Req_B_0, Req_A_1, Req_B_1;
   logic        Rsp_Valid_0, Rsp_Valid_1, Rsp_Ready_0, Rsp_Ready_1;
   logic [31:0] Rsp_Data;
   logic        Rsp_Err;
   logic [31:0] ALU_In_0, ALU_In_1, ALU_Out;
   logic [2:0]  ALU_Sel;
   logic        Busy;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .Req_Valid_0(Req_Valid_0), .Req_Valid_1(Req_Valid_1),
      .Req_Ready_0(Req_Ready_0), .Req_Ready_1(Req_Ready_1),
      .Req_Sel_0(Req_Sel_0), .Req_Sel_1(Req_Sel_1),
      .Req_A_0(Req_A_0), .Req_B_0(Req_B_0),
      .Req_A_1(Req_A_1), .Req_B_1(Req_B_1),
      .Rsp_Valid_0(Rsp_Valid_0), .Rsp_Valid_1(Rsp_Valid_1),
      .Rsp_Ready_0(Rsp_Ready_0), .Rsp_Ready_1(Rsp_Ready_1),
      .Rsp_Data(Rsp_Data), .Rsp_Err(Rsp_Err),
      .ALU_In_0(ALU_In_0), .ALU_In_1(ALU_In_1), .ALU_Sel(ALU_Sel),
      .ALU_Out(ALU_Out), .Busy(Busy)
   );

   // Behavioural ALU; illegal opcodes return garbage the arbiter must mask.
   always_comb begin
      ALU_Out = 32'hDEAD_BEEF;
      case (ALU_Sel)
         3'b000: ALU_Out = ALU_In_0 + ALU_In_1;
         3'b001: ALU_Out = ALU_In_0 - ALU_In_1;
         3'b010: ALU_Out = ALU_In_0 & ALU_In_1;
         3'b011: ALU_Out = ALU_In_0 | ALU_In_1;
         3'b100: ALU_Out = ALU_In_0 ^ ALU_In_1;
         default: ALU_Out = 32'hDEAD_BEEF;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%08h", tag, got);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      rst_n       = 1'b0;
      Req_Valid_0 = 1'b0; Req_Valid_1 = 1'b0;
      Req_Sel_0   = 3'b000; Req_Sel_1 = 3'b000;
      Req_A_0 = '0; Req_B_0 = '0; Req_A_1 = '0; Req_B_1 = '0;
      Rsp_Ready_0 = 1'b1; Rsp_Ready_1 = 1'b1;

      // Reset values
      tick();
      check("rst_busy",    Busy,        0);
      check("rst_rsp_v0",  Rsp_Valid_0, 0);
      check("rst_rsp_v1",  Rsp_Valid_1, 0);
      check("rst_data",    Rsp_Data,    0);
      check("rst_err",     Rsp_Err,     0);
      check("rst_alu_in0", ALU_In_0,    0);
      check("rst_alu_sel", ALU_Sel,     0);
      rst_n = 1'b1;
      tick();

      // Single add from requester 0: 5 + 3
      Req_Valid_0 = 1'b1; Req_Sel_0 = 3'b000; Req_A_0 = 32'h5; Req_B_0 = 32'h3;
      #1;
      check("add_rdy0_c0", Req_Ready_0, 1);
      check("add_rdy1_c0", Req_Ready_1, 0);
      check("add_busy_c0", Busy,        0);
      tick();
      Req_Valid_0 = 1'b0;
      check("add_busy_c1", Busy,        1);
      check("add_rdy0_c1", Req_Ready_0, 0);
      check("add_rspv_c1", Rsp_Valid_0, 0);
      check("add_aluin0",  ALU_In_0,    32'h5);
      tick();
      check("add_rspv_c2", Rsp_Valid_0, 1);
      check("add_data",    Rsp_Data,    32'h8);
      check("add_err",     Rsp_Err,     0);
      check("add_busy_c2", Busy,        1);
      tick();
      check("add_busy_c3", Busy,        0);
      check("add_rspv_c3", Rsp_Valid_0, 0);

      // Both valid every cycle: grants alternate 0,1,0,1
      do_reset();
      Req_Valid_0 = 1'b1; Req_Sel_0 = 3'b001; Req_A_0 = 32'h0;         Req_B_0 = 32'h1;
      Req_Valid_1 = 1'b1; Req_Sel_1 = 3'b100; Req_A_1 = 32'hFFFF_0000; Req_B_1 = 32'h0F0F_0F0F;
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("rr_rdy0_%0d", i), Req_Ready_0, (i % 2 == 0) ? 1 : 0);
         check($sformatf("rr_rdy1_%0d", i), Req_Ready_1, (i % 2 == 1) ? 1 : 0);
         tick();
         tick();
         check($sformatf("rr_rspv0_%0d", i), Rsp_Valid_0, (i % 2 == 0) ? 1 : 0);
         check($sformatf("rr_rspv1_%0d", i), Rsp_Valid_1, (i % 2 == 1) ? 1 : 0);
         check($sformatf("rr_data_%0d", i), Rsp_Data,
               (i % 2 == 0) ? 32'hFFFF_FFFF : 32'hF0F0_0F0F);
         tick();
      end
      Req_Valid_0 = 1'b0;

      // Illegal opcode from requester 1, then a legal and
      Req_Sel_1 = 3'b110; Req_A_1 = 32'h1234; Req_B_1 = 32'h5678;
      #1;
      check("err_rdy1", Req_Ready_1, 1);
      tick();
      Req_Valid_1 = 1'b0;
      tick();
      check("err_rspv1", Rsp_Valid_1, 1);
      check("err_rspv0", Rsp_Valid_0, 0);
      check("err_data",  Rsp_Data,    0);
      check("err_flag",  Rsp_Err,     1);
      tick();
      Req_Valid_1 = 1'b1; Req_Sel_1 = 3'b010; Req_A_1 = 32'hFF; Req_B_1 = 32'h0F;
      #1;
      check("and_rdy1", Req_Ready_1, 1);
      tick();
      Req_Valid_1 = 1'b0;
      tick();
      check("and_rspv1", Rsp_Valid_1, 1);
      check("and_data",  Rsp_Data,    32'hF);
      check("and_err",   Rsp_Err,     0);
      tick();

      // Back-pressure: requester 0 holds off its response for 10 cycles
      Rsp_Ready_0 = 1'b0;
      Req_Valid_0 = 1'b1; Req_Sel_0 = 3'b000; Req_A_0 = 32'h10; Req_B_0 = 32'h20;
      Req_Valid_1 = 1'b1; Req_Sel_1 = 3'b011; Req_A_1 = 32'hA0; Req_B_1 = 32'h0B;
      #1;
      check("bp_rdy0", Req_Ready_0, 1);
      check("bp_rdy1", Req_Ready_1, 0);
      tick();
      Req_Valid_0 = 1'b0;
      tick();
      for (int i = 0; i < 10; i++) begin
         check($sformatf("bp_data_%0d", i), Rsp_Data,    32'h30);
         check($sformatf("bp_rdy1_%0d", i), Req_Ready_1, 0);
         check($sformatf("bp_rspv_%0d", i), Rsp_Valid_0, 1);
         tick();
      end
      Rsp_Ready_0 = 1'b1;
      #1;
      check("bp_rdy1_hs", Req_Ready_1, 0);
      tick();
      check("bp_rdy1_idle", Req_Ready_1, 1);
      tick();
      Req_Valid_1 = 1'b0;
      tick();
      check("bp_rspv1", Rsp_Valid_1, 1);
      check("bp_data1", Rsp_Data,    32'hAB);
      tick();

      // Reset pulsed during EXEC discards the operation and clears the pointer
      Req_Valid_0 = 1'b1; Req_Sel_0 = 3'b000; Req_A_0 = 32'h7; Req_B_0 = 32'h7;
      #1;
      check("mid_rdy0", Req_Ready_0, 1);
      tick();
      Req_Valid_0 = 1'b0;
      check("mid_busy_exec", Busy, 1);
      rst_n = 1'b0;
      #2;
      check("mid_busy_rst",  Busy,     0);
      check("mid_aluin0",    ALU_In_0, 0);
      check("mid_data",      Rsp_Data, 0);
      rst_n = 1'b1;
      tick();
      check("mid_rspv0_a", Rsp_Valid_0, 0);
      tick();
      check("mid_rspv0_b", Rsp_Valid_0, 0);

      // Both valid after reset: requester 0 wins; wrap-around add
      Req_Valid_0 = 1'b1; Req_Sel_0 = 3'b000; Req_A_0 = 32'hFFFF_FFFF; Req_B_0 = 32'h2;
      Req_Valid_1 = 1'b1; Req_Sel_1 = 3'b000; Req_A_1 = 32'h1; Req_B_1 = 32'h1;
      #1;
      check("post_rdy0", Req_Ready_0, 1);
      check("post_rdy1", Req_Ready_1, 0);
      tick();
      Req_Valid_0 = 1'b0; Req_Valid_1 = 1'b0;
      tick();
      check("wrap_rspv0", Rsp_Valid_0, 1);
      check("wrap_data",  Rsp_Data,    32'h1);
      check("wrap_err",   Rsp_Err,     0);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational ALU between two requesters (for example the execute stage and a multi-cycle address/CSR unit). Each requester uses a valid/ready request channel and a valid/ready response channel. The block arbitrates round-robin, registers the granted operands and opcode onto the ALU inputs, captures `ALU_Out` one cycle later, and holds the result until the owning requester accepts it. It sits between the requesters and the ALU and owns all ALU input ports.

## Interface
- `DATA_W` — default 32 — operand and result width; must equal the ALU width (32).
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst_n`  in  1  — reset, asynchronous, active-low.
- `Req_Valid_0` / `Req_Valid_1`  in  1  — request present, requester 0 / 1.
- `Req_Ready_0` / `Req_Ready_1`  out  1  — request accepted this cycle, requester 0 / 1.
- `Req_Sel_0` / `Req_Sel_1`  in  3  — ALU opcode: 000 add, 001 sub, 010 and, 011 or, 100 xor.
- `Req_A_0`, `Req_B_0`, `Req_A_1`, `Req_B_1`  in  DATA_W  — operands.
- `Rsp_Valid_0` / `Rsp_Valid_1`  out  1  — result available for requester 0 / 1.
- `Rsp_Ready_0` / `Rsp_Ready_1`  in  1  — requester takes the result.
- `Rsp_Data`  out  DATA_W  — result; shared by both response channels and qualified by `Rsp_Valid_x`.
- `Rsp_Err`  out  1  — opcode was 101–111; `Rsp_Data` is 0.
- `ALU_In_0`, `ALU_In_1`  out  DATA_W  — driven to the ALU.
- `ALU_Sel`  out  3  — driven to the ALU.
- `ALU_Out`  in  DATA_W  — ALU result (combinational).
- `Busy`  out  1  — high in any state other than IDLE.

## Operation
- FSM has three states.
  - IDLE → EXEC on a request handshake.
  - EXEC → RESP unconditionally.
  - RESP → IDLE when `Rsp_Ready` of the owner is high.
- Arbitration happens in IDLE only.
  - `Grant_x` goes to the only valid requester.
  - If both are valid, `Grant_x` goes to the requester selected by priority pointer `Prio`; `Prio` resets to 0.
- `Req_Ready_x` = (state == IDLE) & `Grant_x`.
  - It is combinational on `Req_Valid`.
  - It is 0 in EXEC and RESP.
  - The ungranted requester sees ready low.
- On handshake:
  - `ALU_In_0`/`ALU_In_1`/`ALU_Sel` registers load A/B/Sel of the granted requester.
  - `Owner` register latches the granted index.
  - `Prio` updates to the non-granted index (it toggles away from the winner, even when only one requester was valid).
- ALU input registers hold their value outside a handshake; they are not cleared after use.
- EXEC, at the clock edge:
  - `Rsp_Data` captures `ALU_Out`.
  - If `ALU_Sel` ≥ 101, `Rsp_Data` captures 0 and `Rsp_Err` = 1; otherwise `Rsp_Err` = 0.
- RESP:
  - `Rsp_Valid_Owner` = 1 and the other `Rsp_Valid` = 0.
  - `Rsp_Data`/`Rsp_Err` stay stable until the handshake.
- Arithmetic wraps modulo 2^DATA_W (add/sub overflow discarded); no flags.

## Timing
- Reset values:
  - Outputs: `Req_Ready_x` 0, `Rsp_Valid_x` 0, `Rsp_Data` 0, `Rsp_Err` 0, `ALU_In_0`/`ALU_In_1` 0, `ALU_Sel` 000, `Busy` 0.
  - Internal: state IDLE, `Prio` 0, `Owner` 0.
- Latency: request handshake at edge N → `Rsp_Valid` high in cycle N+2. Minimum issue interval is 3 cycles (response accepted immediately).
- No new request is accepted in the cycle `Rsp_Ready` completes; the next accept can occur in the following IDLE cycle.
- Back-pressure: `Rsp_Ready` low keeps RESP indefinitely; the other requester stalls, and its `Req_Valid` is held by the requester.
- Simultaneous valid requests: exactly one `Req_Ready` is high. The loser is granted at the next IDLE if it is still valid, because the pointer now favours it.
- Reset asserted mid-operation (EXEC or RESP): asynchronous return to reset values; the in-flight result is discarded with no response.
- Deassertion of `Req_Valid` without a handshake has no effect.

## Test plan
- Reset, then requester 0 sends add A=0x0000_0005, B=0x0000_0003 with `Rsp_Ready_0`=1 → `Req_Ready_0` in cycle 0; `Rsp_Valid_0`=1 with `Rsp_Data`=0x0000_0008 and `Rsp_Err`=0 in cycle 2; `Busy` 1 for cycles 1–2.
- Both requesters valid every cycle: req0 sub 0x0 − 0x1, req1 xor 0xFFFF_0000 ^ 0x0F0F_0F0F → grants alternate 0,1,0,1. Results are 0xFFFF_FFFF to requester 0 and 0xF0F0_0F0F to requester 1, each only on its own `Rsp_Valid`.
- Requester 1 sends `Req_Sel`=110 → `Rsp_Valid_1` with `Rsp_Data`=0 and `Rsp_Err`=1; a following and 0xFF & 0x0F gives 0x0000_000F with `Rsp_Err`=0.
- `Rsp_Ready_0` held low for 10 cycles while requester 1 is valid → `Rsp_Data` stable, `Req_Ready_1` stays 0; requester 1 is granted in the first IDLE cycle after the response handshake.
- `rst_n` pulsed low during EXEC → all outputs return to 0 asynchronously, no `Rsp_Valid` appears, and the next request is granted to requester 0.
- Add 0xFFFF_FFFF + 0x0000_0002 → `Rsp_Data`=0x0000_0001 (wrap-around), `Rsp_Err`=0.
